// File: rtl/lcd_pkg.sv
// Shared HD44780 constants, controller/transfer state encoding and small helpers.
// Pure declarations, no timing; imported by the pulse timer and the top controller.
package lcd_pkg;

    localparam logic [7:0] FUNC_8B2L = 8'h38;
    localparam logic [7:0] DISP_ON   = 8'h0E;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] HOME      = 8'h02;
    localparam logic [7:0] ENTRY_INC = 8'h06;
    localparam logic [7:0] SET_DDRAM = 8'h80;
    localparam logic [7:0] ROW1_BASE = 8'h40;

    // Controller uses INIT/IDLE/ADDR/XFER; the transfer engine uses IDLE/SETUP/EN_HI/EN_LO.
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_XFER,
        ST_SETUP,
        ST_EN_HI,
        ST_EN_LO
    } lcd_state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return FUNC_8B2L;
            2'd1:    return DISP_ON;
            2'd2:    return CLEAR;
            default: return ENTRY_INC;
        endcase
    endfunction

    function automatic logic is_clr_home(input logic [7:0] d);
        return (d == CLEAR) || (d == HOME);
    endfunction

    function automatic logic [7:0] row_addr(input logic row);
        return SET_DDRAM | (row ? ROW1_BASE : 8'h00);
    endfunction

endpackage

// File: rtl/lcd_pulse_timer.sv
// One LCD write: SETUP 1 cycle, EN high EN_CYC, EN low GAP_CYC (+CLR_CYC if extra_wait).
// start is only honoured when idle; done is high during the last EN-low cycle.
module lcd_pulse_timer
    import lcd_pkg::*;
#(
    parameter int unsigned EN_CYC  = 50_000,
    parameter int unsigned GAP_CYC = 50_000,
    parameter int unsigned CLR_CYC = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       rs,
    input  logic       extra_wait,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       done
);

    lcd_state_t  phase;
    logic [31:0] cnt;
    logic [31:0] lo_len;

    assign done = (phase == ST_EN_LO) && (cnt == lo_len - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= ST_IDLE;
            cnt      <= '0;
            lo_len   <= '0;
            lcd_en   <= 1'b0;
            lcd_data <= '0;
            lcd_rs   <= 1'b0;
        end else begin
            case (phase)
                ST_IDLE: begin
                    if (start) begin
                        phase    <= ST_SETUP;
                        lcd_data <= data;
                        lcd_rs   <= rs;
                        lo_len   <= 32'(GAP_CYC) + (extra_wait ? 32'(CLR_CYC) : 32'd0);
                        cnt      <= '0;
                    end
                end
                ST_SETUP: begin
                    phase  <= ST_EN_HI;
                    lcd_en <= 1'b1;
                    cnt    <= '0;
                end
                ST_EN_HI: begin
                    if (cnt == 32'(EN_CYC) - 32'd1) begin
                        phase  <= ST_EN_LO;
                        lcd_en <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_EN_LO: begin
                    // Data/RS keep their value after done; only the next start changes them.
                    if (done) begin
                        phase <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: phase <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 8-bit write-only driver: power-up init, then one request per handshake with cursor tracking.
// Accept to EN rise is 2 cycles (+EN_CYC+GAP_CYC+2 with an inserted address); req_ready low while busy.
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned EN_CYC  = 50_000,
    parameter int unsigned GAP_CYC = 50_000,
    parameter int unsigned CLR_CYC = 100_000,
    parameter int unsigned COLS    = 16,
    parameter int unsigned ROWS    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_is_cmd,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_en,
    output logic       lcd_rw,
    output logic       lcd_rs
);

    lcd_state_t state;
    logic [1:0] init_idx;
    logic       pending;
    logic       row;
    logic [5:0] col;
    logic [7:0] held_char;
    logic       start;
    logic [7:0] s_data;
    logic       s_rs;
    logic       done;
    logic       next_row;

    assign lcd_rw   = 1'b0;
    // Single-row panels always return to row 0; two-row panels alternate.
    assign next_row = (ROWS == 1) ? 1'b0 : ~row;

    lcd_pulse_timer #(
        .EN_CYC (EN_CYC),
        .GAP_CYC(GAP_CYC),
        .CLR_CYC(CLR_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data      (s_data),
        .rs        (s_rs),
        .extra_wait(!s_rs && is_clr_home(s_data)),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_en    (lcd_en),
        .done      (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            init_idx  <= '0;
            pending   <= 1'b0;
            row       <= 1'b0;
            col       <= '0;
            held_char <= '0;
            start     <= 1'b0;
            s_data    <= '0;
            s_rs      <= 1'b0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (!pending) begin
                        start   <= 1'b1;
                        s_data  <= init_cmd(init_idx);
                        s_rs    <= 1'b0;
                        pending <= 1'b1;
                    end else if (done) begin
                        if (init_idx == 2'd3) begin
                            pending   <= 1'b0;
                            state     <= ST_IDLE;
                            req_ready <= 1'b1;
                            init_done <= 1'b1;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                            start    <= 1'b1;
                            s_data   <= init_cmd(init_idx + 2'd1);
                        end
                    end
                end
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        start     <= 1'b1;
                        state     <= ST_XFER;
                        if (req_is_cmd) begin
                            s_data <= req_data;
                            s_rs   <= 1'b0;
                            if (is_clr_home(req_data)) begin
                                row <= 1'b0;
                                col <= '0;
                            end else if (req_data[7]) begin
                                row <= req_data[6];
                                col <= req_data[5:0];
                            end
                        end else if (req_data == 8'h0A) begin
                            s_data <= row_addr(next_row);
                            s_rs   <= 1'b0;
                            row    <= next_row;
                            col    <= '0;
                        end else if (col == 6'(COLS)) begin
                            // Row full: move the DDRAM address first, write the character afterwards.
                            s_data    <= row_addr(next_row);
                            s_rs      <= 1'b0;
                            held_char <= req_data;
                            row       <= next_row;
                            col       <= 6'd1;
                            state     <= ST_ADDR;
                        end else begin
                            s_data <= req_data;
                            s_rs   <= 1'b1;
                            col    <= col + 6'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (done) begin
                        start  <= 1'b1;
                        s_data <= held_char;
                        s_rs   <= 1'b1;
                        state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (done) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
